// File: rtl/first_nios2_system_cpu_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG debug-slave strobes and the
// Avalon-MM debug slave: one-deep JTAG pending slot, round-robin grant, 4-state sequencer.
module first_nios2_system_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteenable,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RD_WAIT, S_RESP} state_t;
  typedef enum logic {SRC_AVS, SRC_JTAG} src_t;

  state_t            state, state_nxt;
  src_t              last_grant, cur_src;
  logic              cur_wr, cur_inc;
  logic              pend_valid, pend_wr, pend_inc;
  logic [ADDR_W-1:0] jtag_addr;
  logic [DATA_W-1:0] jtag_wdata;

  logic avs_req, grant_jtag, grant_avs, done;
  logic str_pend, str_wr, str_inc, str_load;
  logic accept, drop;

  // jdo carries fields for several debug registers; only the OCI memory fields are used here.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign avs_req = avs_read | avs_write;

  always_comb begin : arbitrate
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    grant_jtag = 1'b0;
    grant_avs  = 1'b0;
    if (state == S_IDLE) begin
      if (pend_valid && (!avs_req || last_grant == SRC_AVS)) grant_jtag = 1'b1;
      else if (avs_req)                                      grant_avs  = 1'b1;
    end
  end

  always_comb begin : next_state
    state_nxt = state;
    case (state)
      S_IDLE:    if (grant_jtag || grant_avs) state_nxt = S_ACCESS;
      S_ACCESS:  state_nxt = cur_wr ? S_IDLE : S_RD_WAIT;
      S_RD_WAIT: state_nxt = (cur_src == SRC_JTAG) ? S_IDLE : S_RESP;
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Only the highest-priority strobe of a cycle is considered (b > a > no_action).
  always_comb begin : strobe_decode
    str_pend = 1'b0;
    str_wr   = 1'b0;
    str_inc  = 1'b0;
    str_load = 1'b0;
    if (take_action_ocimem_b) begin
      str_pend = 1'b1;
      str_wr   = 1'b1;
      str_inc  = 1'b1;
    end else if (take_action_ocimem_a) begin
      str_load = 1'b1;
      str_pend = jdo[34];
    end else if (take_no_action_ocimem_a) begin
      str_pend = 1'b1;
      str_inc  = 1'b1;
    end
  end

  // The slot is reusable in the very cycle its current occupant is granted.
  assign accept = str_pend && (!pend_valid || grant_jtag);
  assign drop   = str_pend && pend_valid && !grant_jtag;

  always_ff @(posedge clk or posedge reset) begin : fsm_reg
    // NOTE: non-blocking assignments make every register sample pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin : capture_txn
    if (reset) begin
      last_grant     <= SRC_AVS;
      cur_src        <= SRC_AVS;
      cur_wr         <= 1'b0;
      cur_inc        <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_byteenable <= '0;
    end else if (grant_jtag) begin
      last_grant     <= SRC_JTAG;
      cur_src        <= SRC_JTAG;
      cur_wr         <= pend_wr;
      cur_inc        <= pend_inc;
      ram_addr       <= jtag_addr;
      ram_wdata      <= jtag_wdata;
      ram_byteenable <= 4'hF;
    end else if (grant_avs) begin
      last_grant     <= SRC_AVS;
      cur_src        <= SRC_AVS;
      cur_wr         <= avs_write;
      cur_inc        <= 1'b0;
      ram_addr       <= avs_address;
      ram_wdata      <= avs_writedata;
      ram_byteenable <= avs_byteenable;
    end
  end

  always_ff @(posedge clk or posedge reset) begin : jtag_slot
    if (reset) begin
      pend_valid   <= 1'b0;
      pend_wr      <= 1'b0;
      pend_inc     <= 1'b0;
      jtag_wdata   <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      if (accept) begin
        pend_valid <= 1'b1;
        pend_wr    <= str_wr;
        pend_inc   <= str_inc;
      end else if (grant_jtag) begin
        pend_valid <= 1'b0;
      end
      if (accept && str_wr) jtag_wdata <= jdo[3 +: DATA_W];
      if (drop)          jtag_overrun <= 1'b1;
      else if (str_load) jtag_overrun <= 1'b0;
    end
  end

  // An explicit address load takes precedence over a same-cycle auto-increment.
  always_ff @(posedge clk or posedge reset) begin : jtag_pointer
    if (reset)
      jtag_addr <= '0;
    else if (str_load)
      jtag_addr <= jdo[26 +: ADDR_W];
    else if (state == S_ACCESS && cur_src == SRC_JTAG && cur_inc)
      jtag_addr <= jtag_addr + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin : read_return
    if (reset) begin
      MonDReg      <= '0;
      avs_readdata <= '0;
    end else if (state == S_RD_WAIT) begin
      if (cur_src == SRC_JTAG) MonDReg      <= ram_rdata;
      else                     avs_readdata <= ram_rdata;
    end
  end

  // Write enable is decoded from state so an asynchronous reset kills it immediately.
  assign ram_wren = (state == S_ACCESS) && cur_wr;

  assign done = (state == S_ACCESS && cur_src == SRC_AVS && cur_wr) ||
                (state == S_RESP   && cur_src == SRC_AVS);
  assign avs_waitrequest = avs_req && !done;
  assign jtag_busy       = pend_valid || (state != S_IDLE && cur_src == SRC_JTAG);

endmodule

// File: tb/tb_first_nios2_system_cpu_ocimem_arbiter.sv
// Self-checking bench: directed scenarios plus a random op mix against a
// transaction-level memory/pointer model and the documented cycle latencies.
module tb_first_nios2_system_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [37:0] jdo;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        jtag_busy, jtag_overrun;

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];
  logic [7:0]  m_jaddr, a, x;
  logic [31:0] d, rd, old;
  logic [3:0]  be;
  int          n_chk = 0, n_fail = 0;
  int          kind, lat, cnt, nbad;

  always #5 clk = ~clk;

  first_nios2_system_cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .jdo                     (jdo),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_waitrequest         (avs_waitrequest),
    .avs_readdata            (avs_readdata),
    .ram_addr                (ram_addr),
    .ram_wren                (ram_wren),
    .ram_byteenable          (ram_byteenable),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .jtag_busy               (jtag_busy),
    .jtag_overrun            (jtag_overrun)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Synchronous single-port RAM, read-before-write, one cycle read latency.
  always @(posedge clk) begin
    ram_rdata <= ram[ram_addr];
    if (ram_wren) ram[ram_addr] <= merge(ram[ram_addr], ram_wdata, ram_byteenable);
  end

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd_flag);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[33:26] = addr;
    r[34]    = rd_flag;
    return r[37:0];
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[34:3] = data;
    return r[37:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input logic sa, input logic sb, input logic sn, input logic [37:0] j);
    take_action_ocimem_a    = sa;
    take_action_ocimem_b    = sb;
    take_no_action_ocimem_a = sn;
    jdo                     = j;
    step();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  // Called one cycle after a strobe; returns the cycle index (strobe = 0) where busy drops.
  task automatic wait_jtag_idle(output int c);
    c = 1;
    while (jtag_busy && c < 40) begin
      step();
      c++;
    end
  endtask

  task automatic avs_xfer(input logic wr, input logic [7:0] ad, input logic [31:0] wd,
                          input logic [3:0] en, output int l, output logic [31:0] r);
    avs_address    = ad;
    avs_writedata  = wd;
    avs_byteenable = en;
    avs_write      = wr;
    avs_read       = !wr;
    #1;
    l = 0;
    while (avs_waitrequest && l < 40) begin
      step();
      l++;
    end
    r = avs_readdata;
    step();
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    jdo = '0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ram_wren",     64'(ram_wren),        64'(0));
    check("rst_ram_addr",     64'(ram_addr),        64'(0));
    check("rst_mondreg",      64'(MonDReg),         64'(0));
    check("rst_readdata",     64'(avs_readdata),    64'(0));
    check("rst_overrun",      64'(jtag_overrun),    64'(0));
    check("rst_busy",         64'(jtag_busy),       64'(0));
    check("rst_waitrequest",  64'(avs_waitrequest), 64'(0));
    reset = 1'b0;
    step();

    // Fill the RAM through Avalon so the reference model has known contents.
    nbad = 0;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      avs_xfer(1'b1, 8'(i), d, 4'hF, lat, rd);
      ref_mem[i] = d;
      if (lat != 1) nbad++;
    end
    check("fill_latency_errors", 64'(nbad), 64'(0));

    // Contention right after reset: JTAG wins the first tie, Avalon the next.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    x = 8'($urandom);
    take_no_action_ocimem_a = 1'b1;                          // cycle 0
    step();
    take_no_action_ocimem_a = 1'b0;                          // cycle 1: tie
    avs_address = x; avs_read = 1'b1; avs_byteenable = 4'hF;
    step();
    take_no_action_ocimem_a = 1'b1;                          // cycle 2
    step();
    take_no_action_ocimem_a = 1'b0;                          // cycle 3
    step();                                                  // cycle 4: second tie
    check("tie1_jtag_first",  64'(MonDReg),         64'(ref_mem[0]));
    check("tie1_avs_waiting", 64'(avs_waitrequest), 64'(1));
    cnt = 4;
    while (avs_waitrequest && cnt < 40) begin step(); cnt++; end
    check("tie2_avs_done_cycle", 64'(cnt),           64'(7));
    check("tie2_avs_rdata",      64'(avs_readdata),  64'(ref_mem[x]));
    check("tie2_jtag_not_yet",   64'(MonDReg),       64'(ref_mem[0]));
    step();
    avs_read = 1'b0;                                         // cycle 8
    cnt = 8;
    while (jtag_busy && cnt < 40) begin step(); cnt++; end
    check("tie2_jtag_idle_cycle", 64'(cnt),           64'(11));
    check("tie2_jtag_rdata",      64'(MonDReg),       64'(ref_mem[1]));
    check("tie2_jtag_addr",       64'(dut.jtag_addr), 64'(2));

    // JTAG write burst across the address wrap.
    pulse(1'b1, 1'b0, 1'b0, jdo_a(8'hFE, 1'b0));
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      pulse(1'b0, 1'b1, 1'b0, jdo_b(d));
      wait_jtag_idle(cnt);
      check("burst_idle_cycle", 64'(cnt), 64'(3));
      ref_mem[8'(8'hFE + k)] = d;
      step();
    end
    check("burst_ram_fe",   64'(ram[8'hFE]),     64'(ref_mem[8'hFE]));
    check("burst_ram_ff",   64'(ram[8'hFF]),     64'(ref_mem[8'hFF]));
    check("burst_ram_00",   64'(ram[8'h00]),     64'(ref_mem[8'h00]));
    check("burst_jaddr",    64'(dut.jtag_addr),  64'(1));
    check("burst_overrun",  64'(jtag_overrun),   64'(0));
    m_jaddr = 8'd1;

    // Avalon partial write then read back.
    old = ref_mem[5];
    avs_xfer(1'b1, 8'd5, 32'h1234_5678, 4'b0011, lat, rd);
    check("aw_latency", 64'(lat), 64'(1));
    ref_mem[5] = {old[31:16], 16'h5678};
    avs_xfer(1'b0, 8'd5, 32'h0, 4'hF, lat, rd);
    check("ar_latency", 64'(lat), 64'(3));
    check("ar_be_merge", 64'(rd), 64'({old[31:16], 16'h5678}));

    // Overrun: two next-read strobes while Avalon owns the RAM.
    x = 8'($urandom);
    avs_address = x; avs_read = 1'b1;                        // cycle 0
    step();
    take_no_action_ocimem_a = 1'b1;                          // cycles 1,2
    step();
    step();
    take_no_action_ocimem_a = 1'b0;                          // cycle 3
    check("ovr_set",      64'(jtag_overrun),    64'(1));
    check("ovr_avs_done", 64'(avs_waitrequest), 64'(0));
    check("ovr_avs_data", 64'(avs_readdata),    64'(ref_mem[x]));
    step();
    avs_read = 1'b0;                                         // cycle 4
    cnt = 4;
    while (jtag_busy && cnt < 40) begin step(); cnt++; end
    check("ovr_idle_cycle",   64'(cnt),            64'(7));
    check("ovr_single_read",  64'(MonDReg),        64'(ref_mem[m_jaddr]));
    check("ovr_one_increment", 64'(dut.jtag_addr), 64'(8'(m_jaddr + 1)));
    x = 8'($urandom);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(x, 1'b0));
    check("ovr_cleared",   64'(jtag_overrun),   64'(0));
    check("ovr_addr_load", 64'(dut.jtag_addr),  64'(x));
    m_jaddr = x;

    // Strobe in the same cycle the pending op is granted is accepted.
    take_no_action_ocimem_a = 1'b1;                          // cycles 0,1
    step();
    step();
    take_no_action_ocimem_a = 1'b0;                          // cycle 2
    check("grant_strobe_no_ovr", 64'(jtag_overrun), 64'(0));
    check("grant_strobe_busy",   64'(jtag_busy),    64'(1));
    step();
    step();                                                  // cycle 4
    check("grant_strobe_rd1", 64'(MonDReg), 64'(ref_mem[m_jaddr]));
    cnt = 4;
    while (jtag_busy && cnt < 40) begin step(); cnt++; end
    check("grant_strobe_idle", 64'(cnt),     64'(7));
    check("grant_strobe_rd2",  64'(MonDReg), 64'(ref_mem[8'(m_jaddr + 1)]));
    m_jaddr = 8'(m_jaddr + 2);

    // Random op mix, one transaction at a time.
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 4);
      a    = 8'($urandom);
      d    = $urandom;
      be   = 4'($urandom_range(1, 15));
      case (kind)
        0: begin
          avs_xfer(1'b1, a, d, be, lat, rd);
          check("rnd_aw_latency", 64'(lat), 64'(1));
          ref_mem[a] = merge(ref_mem[a], d, be);
        end
        1: begin
          avs_xfer(1'b0, a, 32'h0, 4'hF, lat, rd);
          check("rnd_ar_latency", 64'(lat), 64'(3));
          check("rnd_ar_data",    64'(rd),  64'(ref_mem[a]));
        end
        2: begin
          pulse(1'b1, 1'b0, 1'b0, jdo_a(a, 1'b0));
          pulse(1'b0, 1'b1, 1'b0, jdo_b(d));
          wait_jtag_idle(cnt);
          check("rnd_jw_idle", 64'(cnt), 64'(3));
          ref_mem[a] = d;
          m_jaddr = 8'(a + 1);
        end
        3: begin
          pulse(1'b0, 1'b0, 1'b1, jdo_b(d));
          wait_jtag_idle(cnt);
          check("rnd_jnext_idle", 64'(cnt),     64'(4));
          check("rnd_jnext_data", 64'(MonDReg), 64'(ref_mem[m_jaddr]));
          m_jaddr = 8'(m_jaddr + 1);
        end
        default: begin
          pulse(1'b1, 1'b0, 1'b0, jdo_a(a, 1'b1));
          wait_jtag_idle(cnt);
          check("rnd_jaddr_rd_idle", 64'(cnt),     64'(4));
          check("rnd_jaddr_rd_data", 64'(MonDReg), 64'(ref_mem[a]));
          m_jaddr = a;
        end
      endcase
    end
    check("rnd_jaddr_final", 64'(dut.jtag_addr), 64'(m_jaddr));

    // Reset in the ACCESS cycle of an Avalon write: no write, held request completes after.
    a   = 8'($urandom);
    d   = ~ref_mem[a];
    avs_address = a; avs_writedata = d; avs_byteenable = 4'hF; avs_write = 1'b1;
    step();                                                  // cycle 1: ACCESS
    check("rstmid_wren_before", 64'(ram_wren), 64'(1));
    reset = 1'b1;
    #1;
    check("rstmid_wren",        64'(ram_wren),        64'(0));
    check("rstmid_waitrequest", 64'(avs_waitrequest), 64'(1));
    check("rstmid_mondreg",     64'(MonDReg),         64'(0));
    check("rstmid_jaddr",       64'(dut.jtag_addr),   64'(0));
    check("rstmid_busy",        64'(jtag_busy),       64'(0));
    step();
    step();
    check("rstmid_no_write", 64'(ram[a]), 64'(ref_mem[a]));
    reset = 1'b0;
    lat = 0;
    while (avs_waitrequest && lat < 40) begin step(); lat++; end
    check("rstmid_resume_latency", 64'(lat), 64'(1));
    step();
    avs_write = 1'b0;
    step();
    ref_mem[a] = d;
    check("rstmid_resume_write", 64'(ram[a]), 64'(d));
    m_jaddr = 8'd0;

    pulse(1'b0, 1'b0, 1'b1, jdo_b(32'h0));
    wait_jtag_idle(cnt);
    check("post_rst_next_read", 64'(MonDReg), 64'(ref_mem[m_jaddr]));

    nbad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) nbad++;
    check("final_ram_contents", 64'(nbad), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
